// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hazard_pkg;

  // FSM state encoding; value 2'd3 is unused and recovers to HZ_IDLE.
  typedef enum logic [1:0] {
    HZ_IDLE    = 2'd0,
    HZ_LU_WAIT = 2'd1,
    HZ_MD_BUSY = 2'd2
  } hz_state_e;

  // Width of the internal bubble down-counter; covers LOAD_STALL-1 <= 6
  // and MD_LAT-2 <= 13.
  localparam int HZ_DCNT_W = 4;

  // Instruction word loaded into a flushed pipeline register (addi x0,x0,0).
  localparam logic [31:0] HZ_NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_mc_sat_counter.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
// Latency: count visible one cycle after the counted cycle.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, rst (async active-high), inc (count this cycle), cnt (value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 pipe: multi-cycle load-use and mul/div stalls, branch flush, perf counters.
// Latency: stall/flush outputs are combinational (0-cycle); state and counters registered.
// Backpressure: stalls hold PC/F_D/D_E; taken branches flush and override any stall.
// Ports: F_D_* (consumer operands), D_E_* (producer load/muldiv), E_M_branch_taken,
//        stall/flush controls to PC_reg/F_D_reg/D_E_reg/E_M_reg, hz_state, stall_cycles, flush_events.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_IDX_W  = 5,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] F_D_rs1_index,
  input  logic [REG_IDX_W-1:0] F_D_rs2_index,
  input  logic                 F_D_rs1_used,
  input  logic                 F_D_rs2_used,
  input  logic                 D_E_mem_read,
  input  logic [REG_IDX_W-1:0] D_E_rd_index,
  input  logic                 D_E_is_muldiv,
  input  logic                 E_M_branch_taken,
  output logic                 PC_stall,
  output logic                 F_D_stall,
  output logic                 D_E_stall,
  output logic                 F_D_flush,
  output logic                 D_E_flush,
  output logic                 E_M_flush,
  output logic [1:0]           hz_state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  // Extra cycles spent in the wait states after the detecting IDLE cycle.
  localparam logic [HZ_DCNT_W-1:0] LU_RELOAD = HZ_DCNT_W'(LOAD_STALL - 1);
  localparam logic [HZ_DCNT_W-1:0] MD_RELOAD = HZ_DCNT_W'((MD_LAT > 2) ? (MD_LAT - 2) : 0);

  hz_state_e             state_q, state_d;
  logic [HZ_DCNT_W-1:0]  cnt_q, cnt_d;
  logic                  lu_hit;
  logic                  pc_stall_c, fd_stall_c, de_stall_c;
  logic                  fd_flush_c, de_flush_c, em_flush_c;

  // x0 never produces a hazard, and only operands actually read count.
  assign lu_hit = D_E_mem_read && (D_E_rd_index != '0) &&
                  ((F_D_rs1_used && (F_D_rs1_index == D_E_rd_index)) ||
                   (F_D_rs2_used && (F_D_rs2_index == D_E_rd_index)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_stall_c = 1'b0;
    fd_stall_c = 1'b0;
    de_stall_c = 1'b0;
    fd_flush_c = 1'b0;
    de_flush_c = 1'b0;
    em_flush_c = 1'b0;

    case (state_q)
      HZ_IDLE: begin
        if (E_M_branch_taken) begin
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
          em_flush_c = 1'b1;
        end else if (D_E_is_muldiv && (MD_LAT > 1)) begin
          // Hold the mul/div in E by freezing everything upstream and
          // bubbling E_M behind it.
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_stall_c = 1'b1;
          em_flush_c = 1'b1;
          if (MD_LAT > 2) begin
            state_d = HZ_MD_BUSY;
            cnt_d   = MD_RELOAD;
          end
        end else if (lu_hit) begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_flush_c = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = HZ_LU_WAIT;
            cnt_d   = LU_RELOAD;
          end
        end
      end

      HZ_LU_WAIT: begin
        if (E_M_branch_taken) begin
          // The waiting consumer is on the wrong path; abandon the wait.
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
          em_flush_c = 1'b1;
          state_d    = HZ_IDLE;
          cnt_d      = '0;
        end else begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_flush_c = 1'b1;
          if (cnt_q <= HZ_DCNT_W'(1)) begin
            state_d = HZ_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - HZ_DCNT_W'(1);
          end
        end
      end

      HZ_MD_BUSY: begin
        if (E_M_branch_taken) begin
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
          em_flush_c = 1'b1;
          state_d    = HZ_IDLE;
          cnt_d      = '0;
        end else if (cnt_q != '0) begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_stall_c = 1'b1;
          em_flush_c = 1'b1;
          cnt_d      = cnt_q - HZ_DCNT_W'(1);
        end else begin
          // Result leaves E this cycle; release the pipe.
          state_d = HZ_IDLE;
        end
      end

      default: begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While in reset the pipe is filled with NOPs and nothing is held.
  always_comb begin
    PC_stall  = rst ? 1'b0 : pc_stall_c;
    F_D_stall = rst ? 1'b0 : fd_stall_c;
    D_E_stall = rst ? 1'b0 : de_stall_c;
    F_D_flush = rst ? 1'b1 : fd_flush_c;
    D_E_flush = rst ? 1'b1 : de_flush_c;
    E_M_flush = rst ? 1'b1 : em_flush_c;
  end

  assign hz_state = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (PC_stall),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (E_M_branch_taken),
    .cnt (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: a legacy-config instance and a multi-cycle instance on shared inputs.
// Latency: outputs sampled on the falling edge after inputs change past the rising edge.
// Backpressure: n/a.
module tb_hazard_ctrl_mc;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, memrd, md, br;

  // Instance a: LOAD_STALL=1, MD_LAT=1 (legacy behaviour)
  logic        a_pc, a_fds, a_des, a_fdf, a_def, a_emf;
  logic [1:0]  a_st;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  // Instance b: LOAD_STALL=3, MD_LAT=4, CNT_W=4
  logic        b_pc, b_fds, b_des, b_fdf, b_def, b_emf;
  logic [1:0]  b_st;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  logic [5:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc, a_fds, a_des, a_fdf, a_def, a_emf};
  assign b_ctl = {b_pc, b_fds, b_des, b_fdf, b_def, b_emf};

  hazard_ctrl_mc #(.REG_IDX_W(5), .LOAD_STALL(1), .MD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .F_D_rs1_index(rs1), .F_D_rs2_index(rs2), .F_D_rs1_used(u1), .F_D_rs2_used(u2),
    .D_E_mem_read(memrd), .D_E_rd_index(rd), .D_E_is_muldiv(md), .E_M_branch_taken(br),
    .PC_stall(a_pc), .F_D_stall(a_fds), .D_E_stall(a_des),
    .F_D_flush(a_fdf), .D_E_flush(a_def), .E_M_flush(a_emf),
    .hz_state(a_st), .stall_cycles(a_stall_cnt), .flush_events(a_flush_cnt)
  );

  hazard_ctrl_mc #(.REG_IDX_W(5), .LOAD_STALL(3), .MD_LAT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .F_D_rs1_index(rs1), .F_D_rs2_index(rs2), .F_D_rs1_used(u1), .F_D_rs2_used(u2),
    .D_E_mem_read(memrd), .D_E_rd_index(rd), .D_E_is_muldiv(md), .E_M_branch_taken(br),
    .PC_stall(b_pc), .F_D_stall(b_fds), .D_E_stall(b_des),
    .F_D_flush(b_fdf), .D_E_flush(b_def), .E_M_flush(b_emf),
    .hz_state(b_st), .stall_cycles(b_stall_cnt), .flush_events(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_stall, F_D_stall, D_E_stall, F_D_flush, D_E_flush, E_M_flush}
  localparam logic [5:0] C0 = 6'b000000;
  localparam logic [5:0] LU = 6'b110010;
  localparam logic [5:0] MD = 6'b111001;
  localparam logic [5:0] BR = 6'b000111;

  typedef struct packed {
    logic       br, md, memrd;
    logic [4:0] rd;
    logic       u1;
    logic [4:0] rs1;
    logic       u2;
    logic [4:0] rs2;
  } in_t;

  typedef struct packed {
    logic [5:0] a_ctl;
    logic [1:0] a_st;
    logic [5:0] b_ctl;
    logic [1:0] b_st;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t ex;
  } vec_t;

  function automatic in_t mi(input logic b, input logic m, input logic mr, input logic [4:0] d,
                             input logic x1, input logic [4:0] s1, input logic x2, input logic [4:0] s2);
    in_t v;
    v.br = b; v.md = m; v.memrd = mr; v.rd = d;
    v.u1 = x1; v.rs1 = s1; v.u2 = x2; v.rs2 = s2;
    return v;
  endfunction

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic drive(input in_t v);
    br = v.br; md = v.md; memrd = v.memrd; rd = v.rd;
    u1 = v.u1; rs1 = v.rs1; u2 = v.u2; rs2 = v.rs2;
  endtask

  vec_t vec[19];

  initial begin
    in_t idle, hz;
    exp_t e;
    idle = mi(0, 0, 0, 0, 0, 0, 0, 0);
    hz   = mi(0, 0, 1, 5, 1, 5, 1, 1);        // ld x5 in D_E; add x6,x5,x1 in F_D

    //                 inputs                         a_ctl a_st  b_ctl b_st
    vec[0]  = '{idle,                           '{C0, 2'd0, C0, 2'd0}};
    vec[1]  = '{hz,                             '{LU, 2'd0, LU, 2'd0}};
    vec[2]  = '{idle,                           '{C0, 2'd0, LU, 2'd1}};
    vec[3]  = '{idle,                           '{C0, 2'd0, LU, 2'd1}};
    vec[4]  = '{idle,                           '{C0, 2'd0, C0, 2'd0}};
    vec[5]  = '{mi(0, 0, 1, 0, 1, 0, 0, 0),     '{C0, 2'd0, C0, 2'd0}};  // rd=x0
    vec[6]  = '{mi(0, 0, 1, 5, 0, 5, 0, 5),     '{C0, 2'd0, C0, 2'd0}};  // operands unused
    vec[7]  = '{mi(0, 0, 1, 7, 1, 0, 1, 7),     '{LU, 2'd0, LU, 2'd0}};  // rs2 hazard
    vec[8]  = '{mi(1, 0, 0, 0, 0, 0, 0, 0),     '{BR, 2'd0, BR, 2'd1}};  // branch kills LU_WAIT
    vec[9]  = '{idle,                           '{C0, 2'd0, C0, 2'd0}};
    vec[10] = '{mi(1, 0, 1, 5, 1, 5, 1, 1),     '{BR, 2'd0, BR, 2'd0}};  // branch beats lu_hit
    vec[11] = '{mi(0, 1, 0, 0, 0, 0, 0, 0),     '{C0, 2'd0, MD, 2'd0}};  // mul enters E
    vec[12] = '{mi(0, 1, 0, 0, 0, 0, 0, 0),     '{C0, 2'd0, MD, 2'd2}};
    vec[13] = '{mi(0, 1, 0, 0, 0, 0, 0, 0),     '{C0, 2'd0, MD, 2'd2}};
    vec[14] = '{mi(0, 1, 0, 0, 0, 0, 0, 0),     '{C0, 2'd0, C0, 2'd2}};  // release cycle
    vec[15] = '{idle,                           '{C0, 2'd0, C0, 2'd0}};
    vec[16] = '{mi(0, 1, 1, 5, 1, 5, 1, 1),     '{LU, 2'd0, MD, 2'd0}};  // both: mul wins in b
    vec[17] = '{mi(1, 1, 0, 0, 0, 0, 0, 0),     '{BR, 2'd0, BR, 2'd2}};  // branch on 2nd stall cycle
    vec[18] = '{idle,                           '{C0, 2'd0, C0, 2'd0}};

    rst = 1'b1;
    drive(idle);

    // Reset state
    #3;
    chk("rst_a_ctl", 32'(a_ctl), 32'(BR));
    chk("rst_b_ctl", 32'(b_ctl), 32'(BR));
    chk("rst_a_st", 32'(a_st), 0);
    chk("rst_b_st", 32'(b_st), 0);
    chk("rst_a_stall_cnt", 32'(a_stall_cnt), 0);
    chk("rst_b_flush_cnt", 32'(b_flush_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table: one row per cycle, expectation queued when driven, popped when sampled
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      drive(vec[i].in);
      sb.push_back(vec[i].ex);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("row%0d_a_ctl", i), 32'(a_ctl), 32'(e.a_ctl));
      chk($sformatf("row%0d_a_st", i),  32'(a_st),  32'(e.a_st));
      chk($sformatf("row%0d_b_ctl", i), 32'(b_ctl), 32'(e.b_ctl));
      chk($sformatf("row%0d_b_st", i),  32'(b_st),  32'(e.b_st));
    end
    chk("tbl_a_stall_cnt", 32'(a_stall_cnt), 3);
    chk("tbl_b_stall_cnt", 32'(b_stall_cnt), 8);
    chk("tbl_a_flush_cnt", 32'(a_flush_cnt), 3);
    chk("tbl_b_flush_cnt", 32'(b_flush_cnt), 3);

    // Asynchronous reset in the middle of MD_BUSY
    @(posedge clk); #1;
    drive(mi(0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mdrst_b_ctl_pre", 32'(b_ctl), 32'(MD));
    @(posedge clk); #1;
    chk("mdrst_b_st_busy", 32'(b_st), 2);
    rst = 1'b1;
    #1;
    chk("mdrst_b_st", 32'(b_st), 0);
    chk("mdrst_b_ctl", 32'(b_ctl), 32'(BR));
    chk("mdrst_a_ctl", 32'(a_ctl), 32'(BR));
    chk("mdrst_b_stall_cnt", 32'(b_stall_cnt), 0);
    chk("mdrst_a_flush_cnt", 32'(a_flush_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);

    // Counter saturation: 20 back-to-back stall cycles, then 17 branch cycles
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(hz);
    end
    @(posedge clk); #1;
    drive(idle);
    chk("sat_b_stall_cnt", 32'(b_stall_cnt), 15);
    chk("sat_a_stall_cnt", 32'(a_stall_cnt), 20);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      drive(mi(1, 0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    chk("sat_b_ctl_br", 32'(b_ctl), 32'(BR));
    @(posedge clk); #1;
    drive(idle);
    chk("sat_b_flush_cnt", 32'(b_flush_cnt), 15);
    chk("sat_a_flush_cnt", 32'(a_flush_cnt), 17);
    chk("sat_b_stall_hold", 32'(b_stall_cnt), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
